// File: rtl/punc_fetch_unit_pkg.sv
// Shared definitions for the PUnC instruction-fetch stage:
// fetch FSM state encodings, the LC3 word width, the default reset PC
// and the memory-latency counter helper.
package punc_fetch_unit_pkg;

    localparam int LC3_WORD_W = 16;

    localparam logic [LC3_WORD_W-1:0] PUNC_RESET_PC = 16'h0000;

    // Latency counter width; covers MEM_LATENCY values 1..4.
    localparam int LAT_CNT_W = 2;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DONE = 2'd2
    } fetch_state_t;

    // Value loaded into the latency counter when a read is issued.
    function automatic logic [LAT_CNT_W-1:0] lat_load(input int lat);
        return LAT_CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/punc_pc_reg.sv
// PC register for the fetch stage, with a one-entry pending-load slot.
// Priority per cycle:
//   apply (DONE->IDLE) : a load arriving this cycle, else the pending value
//   inc_en (WAIT capture): fetch_addr+1, while a concurrent load is parked
//   ld_busy            : park the load (last write wins)
//   ld_idle            : direct load in IDLE
module punc_pc_reg
    import punc_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = LC3_WORD_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PUNC_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_idle,
    input  logic              ld_busy,
    input  logic [ADDR_W-1:0] din,
    input  logic              inc_en,
    input  logic [ADDR_W-1:0] inc_val,
    input  logic              apply,
    output logic [ADDR_W-1:0] pc
);

    logic              pend_valid;
    logic [ADDR_W-1:0] pend_val;

    // PC update with load / increment / pending-override priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_val   <= '0;
        end else if (apply) begin
            if (ld_busy) begin
                pc <= din;
            end else if (pend_valid) begin
                pc <= pend_val;
            end
            pend_valid <= 1'b0;
        end else begin
            if (inc_en) begin
                pc <= inc_val;
            end else if (ld_idle) begin
                pc <= din;
            end
            if (ld_busy) begin
                pend_valid <= 1'b1;
                pend_val   <= din;
            end
        end
    end

endmodule

// File: rtl/punc_fetch_unit.sv
// PUnC LC3 instruction-fetch stage: owns PC and IR, reads mem[PC] on a
// fetch command, latches IR, post-increments PC and pulses fetch_done.
// Optional perf counters are built when PUNC_FETCH_PERF_EN is defined.
//
// Handshake: fetch_ready is high in IDLE while not halted. A fetch is
// accepted on any cycle where fetch_req and fetch_ready are both high;
// there is no queuing, so a request seen while halted or busy is dropped.
// fetch_done pulses once, MEM_LATENCY+1 cycles after acceptance.
module punc_fetch_unit
    import punc_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = LC3_WORD_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(PUNC_RESET_PC),
    parameter int                MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    output logic              fetch_ready,
    output logic              fetch_done,
    input  logic              halt,
    input  logic              pc_ld,
    input  logic [ADDR_W-1:0] pc_din,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [DATA_W-1:0] mem_r_data,
    output fetch_state_t      dbg_state
`ifdef PUNC_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetches,
    output logic [31:0]       perf_stall_cycles
`endif
);

    fetch_state_t         state;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic [ADDR_W-1:0]    fetch_addr;
    logic                 issue;
    logic                 capture;
    logic [ADDR_W-1:0]    issue_addr;

    assign issue      = (state == FETCH_IDLE) && fetch_req && !halt;
    assign issue_addr = pc_ld ? pc_din : pc;
    assign capture    = (state == FETCH_WAIT) && (lat_cnt == '0);

    // Fetch FSM, latency counter, held fetch address and IR capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH_IDLE;
            lat_cnt    <= '0;
            fetch_addr <= '0;
            ir         <= '0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (issue) begin
                        fetch_addr <= issue_addr;
                        lat_cnt    <= lat_load(MEM_LATENCY);
                        state      <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (lat_cnt == '0) begin
                        ir    <= mem_r_data;
                        state <= FETCH_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                FETCH_DONE: begin
                    state <= FETCH_IDLE;
                end
                default: begin
                    state <= FETCH_IDLE;
                end
            endcase
        end
    end

    // Read address: live mux on the issue cycle, held while the read is in flight
    always_comb begin
        mem_r_addr = '0;
        case (state)
            FETCH_IDLE: if (issue) mem_r_addr = issue_addr;
            FETCH_WAIT,
            FETCH_DONE: mem_r_addr = fetch_addr;
            default:    mem_r_addr = '0;
        endcase
    end

    assign mem_r_en    = issue;
    assign fetch_ready = (state == FETCH_IDLE) && !halt;
    assign fetch_done  = (state == FETCH_DONE);
    assign dbg_state   = state;

    punc_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .ld_idle ((state == FETCH_IDLE) && pc_ld && !issue),
        .ld_busy ((state != FETCH_IDLE) && pc_ld),
        .din     (pc_din),
        .inc_en  (capture),
        .inc_val (fetch_addr + ADDR_W'(1)),
        .apply   (state == FETCH_DONE),
        .pc      (pc)
    );

`ifdef PUNC_FETCH_PERF_EN
    // Saturating fetch and halt-stall counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetches      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (fetch_done && (perf_fetches != 32'hFFFF_FFFF)) begin
                perf_fetches <= perf_fetches + 32'd1;
            end
            if ((state == FETCH_IDLE) && halt && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_punc_fetch_unit.sv
// Directed bench for punc_fetch_unit: one instance with MEM_LATENCY=1
// (prefix a_) and one with MEM_LATENCY=3 (prefix b_), each fed by a
// latency-accurate memory model that returns 16'hDEAD outside its data window.
module tb_punc_fetch_unit;
  import punc_fetch_unit_pkg::*;

  logic clk;
  logic rst;

  logic        a_fetch_req, a_halt, a_pc_ld;
  logic [15:0] a_pc_din;
  logic        a_fetch_ready, a_fetch_done, a_mem_r_en;
  logic [15:0] a_pc, a_ir, a_mem_r_addr, a_mem_r_data;
  fetch_state_t a_dbg_state;

  logic        b_fetch_req, b_halt, b_pc_ld;
  logic [15:0] b_pc_din;
  logic        b_fetch_ready, b_fetch_done, b_mem_r_en;
  logic [15:0] b_pc, b_ir, b_mem_r_addr, b_mem_r_data;
  fetch_state_t b_dbg_state;

`ifdef PUNC_FETCH_PERF_EN
  logic [31:0] a_perf_fetches, a_perf_stall_cycles;
  logic [31:0] b_perf_fetches, b_perf_stall_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  punc_fetch_unit #(.MEM_LATENCY(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .fetch_req(a_fetch_req), .fetch_ready(a_fetch_ready), .fetch_done(a_fetch_done),
    .halt(a_halt), .pc_ld(a_pc_ld), .pc_din(a_pc_din),
    .pc(a_pc), .ir(a_ir),
    .mem_r_en(a_mem_r_en), .mem_r_addr(a_mem_r_addr), .mem_r_data(a_mem_r_data),
    .dbg_state(a_dbg_state)
`ifdef PUNC_FETCH_PERF_EN
    , .perf_fetches(a_perf_fetches), .perf_stall_cycles(a_perf_stall_cycles)
`endif
  );

  punc_fetch_unit #(.MEM_LATENCY(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .fetch_req(b_fetch_req), .fetch_ready(b_fetch_ready), .fetch_done(b_fetch_done),
    .halt(b_halt), .pc_ld(b_pc_ld), .pc_din(b_pc_din),
    .pc(b_pc), .ir(b_ir),
    .mem_r_en(b_mem_r_en), .mem_r_addr(b_mem_r_addr), .mem_r_data(b_mem_r_data),
    .dbg_state(b_dbg_state)
`ifdef PUNC_FETCH_PERF_EN
    , .perf_fetches(b_perf_fetches), .perf_stall_cycles(b_perf_stall_cycles)
`endif
  );

  // ---------------- memory models ----------------
  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    case (addr)
      16'h0000: return 16'h1221;
      16'h3000: return 16'h0E05;
      16'hFFFF: return 16'hABCD;
      default:  return addr ^ 16'h5A5A;
    endcase
  endfunction

  logic       a_busy, b_busy;
  logic [1:0] a_remain, b_remain;
  logic [15:0] a_raddr, b_raddr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_busy <= 1'b0; a_remain <= 2'd0; a_raddr <= 16'h0;
    end else if (a_mem_r_en) begin
      a_busy <= 1'b1; a_remain <= 2'd0; a_raddr <= a_mem_r_addr;
    end else if (a_busy) begin
      if (a_remain == 2'd0) a_busy <= 1'b0;
      else a_remain <= a_remain - 2'd1;
    end
  end
  assign a_mem_r_data = (a_busy && a_remain == 2'd0) ? mem_word(a_raddr) : 16'hDEAD;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b_busy <= 1'b0; b_remain <= 2'd0; b_raddr <= 16'h0;
    end else if (b_mem_r_en) begin
      b_busy <= 1'b1; b_remain <= 2'd2; b_raddr <= b_mem_r_addr;
    end else if (b_busy) begin
      if (b_remain == 2'd0) b_busy <= 1'b0;
      else b_remain <= b_remain - 2'd1;
    end
  end
  assign b_mem_r_data = (b_busy && b_remain == 2'd0) ? mem_word(b_raddr) : 16'hDEAD;

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    a_fetch_req = 0; a_halt = 0; a_pc_ld = 0; a_pc_din = 16'h0;
    b_fetch_req = 0; b_halt = 0; b_pc_ld = 0; b_pc_din = 16'h0;
    #2;
    check("rst_pc",    32'(a_pc), 32'h0000);
    check("rst_ir",    32'(a_ir), 32'h0000);
    check("rst_done",  32'(a_fetch_done), 32'h0);
    check("rst_en",    32'(a_mem_r_en), 32'h0);
    check("rst_addr",  32'(a_mem_r_addr), 32'h0000);
    check("rst_state", 32'(a_dbg_state), 32'(FETCH_IDLE));
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_ready", 32'(a_fetch_ready), 32'h1);

    // Test 1: MEM_LATENCY=1 fetch from 0x0000
    a_fetch_req = 1'b1;
    settle();
    check("t1_en_c0",   32'(a_mem_r_en), 32'h1);
    check("t1_addr_c0", 32'(a_mem_r_addr), 32'h0000);
    tick();
    a_fetch_req = 1'b0;
    settle();
    check("t1_state_c1", 32'(a_dbg_state), 32'(FETCH_WAIT));
    check("t1_en_c1",    32'(a_mem_r_en), 32'h0);
    check("t1_done_c1",  32'(a_fetch_done), 32'h0);
    check("t1_ready_c1", 32'(a_fetch_ready), 32'h0);
    tick();
    check("t1_done_c2", 32'(a_fetch_done), 32'h1);
    check("t1_ir",      32'(a_ir), 32'h1221);
    check("t1_pc",      32'(a_pc), 32'h0001);
    tick();
    check("t1_done_c3",  32'(a_fetch_done), 32'h0);
    check("t1_ready_c3", 32'(a_fetch_ready), 32'h1);

    // Test 2: MEM_LATENCY=3 fetch from 0x3000
    b_pc_ld = 1'b1; b_pc_din = 16'h3000;
    tick();
    b_pc_ld = 1'b0;
    settle();
    check("t2_pc_load", 32'(b_pc), 32'h3000);
    b_fetch_req = 1'b1;
    settle();
    check("t2_en_c0",   32'(b_mem_r_en), 32'h1);
    check("t2_addr_c0", 32'(b_mem_r_addr), 32'h3000);
    tick();
    b_fetch_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      settle();
      check($sformatf("t2_done_c%0d", k), 32'(b_fetch_done), 32'h0);
      check($sformatf("t2_addr_c%0d", k), 32'(b_mem_r_addr), 32'h3000);
      check($sformatf("t2_en_c%0d", k),   32'(b_mem_r_en), 32'h0);
      tick();
    end
    check("t2_done_c4", 32'(b_fetch_done), 32'h1);
    check("t2_addr_c4", 32'(b_mem_r_addr), 32'h3000);
    check("t2_ir",      32'(b_ir), 32'h0E05);
    check("t2_pc",      32'(b_pc), 32'h3001);
    tick();
    check("t2_done_c5", 32'(b_fetch_done), 32'h0);

    // Test 3: pc_ld with fetch_req in one IDLE cycle, address 0xFFFF wraps
    a_pc_ld = 1'b1; a_pc_din = 16'hFFFF; a_fetch_req = 1'b1;
    settle();
    check("t3_en_c0",   32'(a_mem_r_en), 32'h1);
    check("t3_addr_c0", 32'(a_mem_r_addr), 32'hFFFF);
    tick();
    a_pc_ld = 1'b0; a_fetch_req = 1'b0;
    tick();
    check("t3_done", 32'(a_fetch_done), 32'h1);
    check("t3_ir",   32'(a_ir), 32'hABCD);
    check("t3_pc",   32'(a_pc), 32'h0000);
    tick();

    // Test 4: pc_ld during WAIT overrides the post-increment after DONE
    a_fetch_req = 1'b1;
    tick();
    a_fetch_req = 1'b0;
    a_pc_ld = 1'b1; a_pc_din = 16'h4000;
    settle();
    check("t4_state_wait", 32'(a_dbg_state), 32'(FETCH_WAIT));
    tick();
    a_pc_ld = 1'b0;
    settle();
    check("t4_done",    32'(a_fetch_done), 32'h1);
    check("t4_ir",      32'(a_ir), 32'h1221);
    check("t4_pc_done", 32'(a_pc), 32'h0001);
    tick();
    check("t4_pc_after", 32'(a_pc), 32'h4000);
    check("t4_ready",    32'(a_fetch_ready), 32'h1);

    // Test 5: halt blocks fetch_req for 5 cycles
    a_halt = 1'b1; a_fetch_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("t5_en_%0d", k),    32'(a_mem_r_en), 32'h0);
      check($sformatf("t5_ready_%0d", k), 32'(a_fetch_ready), 32'h0);
      tick();
    end
    check("t5_state", 32'(a_dbg_state), 32'(FETCH_IDLE));
    check("t5_ir",    32'(a_ir), 32'h1221);
    check("t5_pc",    32'(a_pc), 32'h4000);
`ifdef PUNC_FETCH_PERF_EN
    check("t5_perf_stall",   a_perf_stall_cycles, 32'd5);
    check("t5_perf_fetches", a_perf_fetches, 32'd3);
    check("t5_perf_b",       b_perf_fetches, 32'd1);
`endif
    a_halt = 1'b0; a_fetch_req = 1'b0;
    tick();

    // Test 6: reset asserted in WAIT discards the fetch
    a_fetch_req = 1'b1;
    tick();
    a_fetch_req = 1'b0;
    settle();
    check("t6_state_wait", 32'(a_dbg_state), 32'(FETCH_WAIT));
    rst = 1'b1;
    settle();
    check("t6_pc_rst",    32'(a_pc), 32'h0000);
    check("t6_ir_rst",    32'(a_ir), 32'h0000);
    check("t6_state_rst", 32'(a_dbg_state), 32'(FETCH_IDLE));
    check("t6_addr_rst",  32'(a_mem_r_addr), 32'h0000);
    tick();
    check("t6_done_rst", 32'(a_fetch_done), 32'h0);
    rst = 1'b0;
    tick();
    check("t6_done_post", 32'(a_fetch_done), 32'h0);
`ifdef PUNC_FETCH_PERF_EN
    check("t6_perf_clr", a_perf_fetches, 32'd0);
`endif
    a_fetch_req = 1'b1;
    settle();
    check("t6_en_c0",   32'(a_mem_r_en), 32'h1);
    check("t6_addr_c0", 32'(a_mem_r_addr), 32'h0000);
    tick();
    a_fetch_req = 1'b0;
    tick();
    check("t6_done", 32'(a_fetch_done), 32'h1);
    check("t6_ir",   32'(a_ir), 32'h1221);
    check("t6_pc",   32'(a_pc), 32'h0001);
    tick();
    check("t6_idle", 32'(a_dbg_state), 32'(FETCH_IDLE));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/punc_fetch_unit.md
Name: punc_fetch_unit

Overview:
- Instruction-fetch stage for the PUnC LC3 core; sits between PUnCControl and the unified memory read port.
- Owns PC and IR.
- On a fetch command from the control FSM, reads mem[PC], latches IR, increments PC, and signals completion.
- Accepts PC overwrites from the datapath (BR/JMP/JSR/TRAP targets).

Parameters:
- ADDR_W, 16, PC / memory address width
- DATA_W, 16, instruction word width
- RESET_PC, 16'h0000, PC value after reset
- MEM_LATENCY, 1, cycles from mem_r_en to valid mem_r_data; legal range 1..4

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- fetch_req  in  1  control requests a fetch; sampled only in IDLE
- fetch_ready  out  1  high in IDLE and not halted
- fetch_done  out  1  one-cycle pulse; IR updated this cycle
- halt  in  1  level; blocks new fetches while high
- pc_ld  in  1  load PC from pc_din
- pc_din  in  ADDR_W  new PC value
- pc  out  ADDR_W  current PC; post-increment after fetch
- ir  out  DATA_W  current instruction register
- mem_r_en  out  1  memory read strobe
- mem_r_addr  out  ADDR_W  memory read address
- mem_r_data  in  DATA_W  memory read data

Behaviour:
- Reset (async, any state, including mid-fetch):
  - state=IDLE, pc=RESET_PC, ir=0
  - fetch_done=0, mem_r_en=0, mem_r_addr=0
  - pending-load register cleared; any in-flight read is discarded.
- States: IDLE, WAIT, DONE (2-bit encoding).
- IDLE:
  - fetch_ready = ~halt.
  - If fetch_req & ~halt:
    - mem_r_en=1 for exactly this one cycle.
    - mem_r_addr = pc_ld ? pc_din : pc.
    - Latency counter loaded with MEM_LATENCY-1; go to WAIT.
  - fetch_req while halt is high is ignored; no queuing.
- WAIT:
  - mem_r_addr held stable; mem_r_en=0; counter decrements each cycle.
  - When counter==0: ir <= mem_r_data; pc <= fetch_addr+1 (mod 2^ADDR_W; 16'hFFFF wraps to 16'h0000); go to DONE.
  - With MEM_LATENCY=1, WAIT lasts exactly one cycle.
- DONE:
  - fetch_done=1 for this single cycle; return to IDLE.
  - Total latency from fetch_req to fetch_done = MEM_LATENCY+1 cycles.
- pc_ld handling:
  - In IDLE without fetch_req: pc <= pc_din next edge.
  - In IDLE with fetch_req: pc_din is the fetch address, and the resulting pc is pc_din+1.
  - In WAIT/DONE: captured into a one-entry pending register (last write wins). It is applied on the cycle DONE→IDLE and overrides the post-increment value.
- ir is held between fetches and never changes outside the WAIT capture.
- pc and ir are registered outputs; fetch_ready, fetch_done and mem_r_en are decoded from state.

Optional Feature:
- Macro: PUNC_FETCH_PERF_EN.
- Defined: adds outputs perf_fetches (32b) and perf_stall_cycles (32b).
  - perf_fetches increments on each fetch_done.
  - perf_stall_cycles increments each cycle in IDLE with halt=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/Defines.v additions:
  - fetch state encodings (FETCH_IDLE=2'd0, FETCH_WAIT=2'd1, FETCH_DONE=2'd2)
  - `PUNC_RESET_PC`
  - LC3 word width
- One natural sub-module: punc_pc_reg. Holds PC plus the pending-load register, and implements the load/increment/pending priority.
- The FSM and latency counter stay in the top module.

Test Plan:
- Reset, mem[0x0000]=16'h1221, MEM_LATENCY=1, fetch_req pulse → mem_r_addr=0x0000 and mem_r_en in cycle 0; fetch_done in cycle 2; ir=16'h1221, pc=0x0001.
- MEM_LATENCY=3, pc=0x3000, mem[0x3000]=16'h0E05, fetch_req → fetch_done 4 cycles later; ir=16'h0E05, pc=0x3001; mem_r_addr stable throughout.
- pc_ld=1 with pc_din=0xFFFF and fetch_req in the same IDLE cycle → mem_r_addr=0xFFFF; after done, pc=0x0000 (wrap).
- pc_ld with pc_din=0x4000 during WAIT → after fetch_done, pc=0x4000, not fetch_addr+1.
- halt=1 with fetch_req held for 5 cycles → no mem_r_en, fetch_ready=0; with PERF_EN, perf_stall_cycles=5.
- rst asserted in WAIT → pc=RESET_PC and ir=0 immediately; no fetch_done; the next fetch proceeds normally.
